branch_sequencer: RTL and testbench

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

---
 rtl/branch_sequencer_if.sv | 37 +++
 rtl/branch_sequencer.sv | 146 ++++++++++++++
 tb/tb_branch_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/branch_sequencer_if.sv
// Branch sequencer bus: branch resolution in, fetch PC and flush control out.
// Optional build macro: BRANCH_STATS_EN adds the taken/not-taken statistics counters.
interface branch_sequencer_if;
    localparam int unsigned PC_W   = 16;
    localparam int unsigned STAT_W = 16;

    logic              br_valid;
    logic              jump;
    logic [PC_W-1:0]   target;
    logic              stall;
    logic              br_ready;
    logic [PC_W-1:0]   pc;
    logic              flush;
    logic              redirect;
`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] taken_cnt;
    logic [STAT_W-1:0] nottaken_cnt;
`endif

    // Upstream side: presents branch resolutions and stall, observes the fetch PC.
    modport master (
        output br_valid, jump, target, stall,
        input  br_ready, pc, flush, redirect
`ifdef BRANCH_STATS_EN
        , input taken_cnt, nottaken_cnt
`endif
    );

    // Sequencer side.
    modport slave (
        input  br_valid, jump, target, stall,
        output br_ready, pc, flush, redirect
`ifdef BRANCH_STATS_EN
        , output taken_cnt, nottaken_cnt
`endif
    );
endinterface

// File: rtl/branch_sequencer.sv
// Branch sequencer: advances the fetch PC, redirects on taken branches and
// holds flush for FLUSH_CYCLES cycles behind each redirect.
// Optional build macro: BRANCH_STATS_EN adds saturating taken/not-taken counters.
module branch_sequencer #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    branch_sequencer_if.slave  bus
);
    localparam int unsigned PC_W   = 16;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               flush_q, flush_d;
    logic               redirect_q, redirect_d;
    logic               br_ready_q, br_ready_d;

    logic               accept_c;
    logic               take_c;

    // A branch is only seen while running; anything presented otherwise is dropped.
    assign accept_c = bus.br_valid & br_ready_q;
    assign take_c   = accept_c & bus.jump;

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (take_c) begin
                    // A taken branch wins over stall: the target must still be fetched.
                    pc_d       = bus.target;
                    cnt_d      = CNT_W'(FLUSH_CYCLES);
                    redirect_d = 1'b1;
                    state_d    = ST_FLUSH;
                end else if (bus.stall) begin
                    state_d = ST_HOLD;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end

            ST_FLUSH: begin
                // PC sits on the target; the last flush cycle is the one that reads 1.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = bus.stall ? ST_HOLD : ST_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_HOLD: begin
                // Leaving HOLD advances the PC on the same edge.
                if (!bus.stall) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase

        flush_d    = (state_d == ST_FLUSH);
        br_ready_d = (state_d == ST_RUN);
    end

    // State, PC and registered control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            redirect_q <= 1'b0;
            br_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            redirect_q <= redirect_d;
            br_ready_q <= br_ready_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.flush    = flush_q;
    assign bus.redirect = redirect_q;
    assign bus.br_ready = br_ready_q;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] taken_q, taken_d;
    logic [STAT_W-1:0] nottaken_q, nottaken_d;

    // Saturating counts of accepted branches split by outcome.
    always_comb begin
        taken_d    = taken_q;
        nottaken_d = nottaken_q;
        if (accept_c) begin
            if (bus.jump) begin
                if (taken_q != '1) begin
                    taken_d = taken_q + STAT_W'(1);
                end
            end else begin
                if (nottaken_q != '1) begin
                    nottaken_d = nottaken_q + STAT_W'(1);
                end
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_q    <= '0;
            nottaken_q <= '0;
        end else begin
            taken_q    <= taken_d;
            nottaken_q <= nottaken_d;
        end
    end

    assign bus.taken_cnt    = taken_q;
    assign bus.nottaken_cnt = nottaken_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer (RESET_PC=0010, FLUSH_CYCLES=2).
module tb_branch_sequencer;
    logic clk;
    logic reset;

    branch_sequencer_if bus ();

    branch_sequencer #(
        .RESET_PC     (16'h0010),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        br_valid;
        logic        jump;
        logic        stall;
        logic [15:0] target;
        logic [15:0] exp_pc;
        logic        exp_flush;
        logic        exp_redirect;
        logic        exp_ready;
    } vec_t;

    vec_t vecs[$];
    int   n_total;
    int   n_pass;

    function automatic void add(input logic v, input logic j, input logic s,
                                input logic [15:0] t, input logic [15:0] epc,
                                input logic ef, input logic er, input logic erdy);
        vec_t r;
        r.br_valid = v;  r.jump = j;  r.stall = s;  r.target = t;
        r.exp_pc = epc;  r.exp_flush = ef;  r.exp_redirect = er;  r.exp_ready = erdy;
        vecs.push_back(r);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic v, input logic j, input logic s, input logic [15:0] t);
        bus.br_valid = v;
        bus.jump     = j;
        bus.stall    = s;
        bus.target   = t;
    endtask

    // Active edge plus a small settle; all sampling happens here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [15:0] epc, input logic ef,
                            input logic er, input logic erdy);
        chk({tag, ".pc"},       bus.pc,              epc);
        chk({tag, ".flush"},    16'(bus.flush),      16'(ef));
        chk({tag, ".redirect"}, 16'(bus.redirect),   16'(er));
        chk({tag, ".br_ready"}, 16'(bus.br_ready),   16'(erdy));
    endtask

`ifdef BRANCH_STATS_EN
    int exp_taken;
    int exp_nt;
`endif

    initial begin
        n_total = 0;
        n_pass  = 0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        reset = 1'b1;

        // Reset state, visible without relying on an edge.
        #12;
        chk_outs("reset", 16'h0010, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        // Idle run from reset up to 0020.
        for (int i = 1; i <= 16; i++) begin
            add(1'b0, 1'b0, 1'b0, 16'h0000, 16'(16'h0010 + i), 1'b0, 1'b0, 1'b1);
        end
        // Taken branch at 0020; a branch presented during FLUSH is dropped.
        add(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0100, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 16'h0300, 16'h0100, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0101, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0102, 1'b0, 1'b0, 1'b1);
        // Not-taken branch is a plain increment.
        add(1'b1, 1'b0, 1'b0, 16'h0500, 16'h0103, 1'b0, 1'b0, 1'b1);
        // Three stall cycles; a branch in HOLD is dropped; release increments.
        add(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0103, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'h0777, 16'h0103, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0103, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0104, 1'b0, 1'b0, 1'b1);
        // Taken branch beats stall, flushes, then parks in HOLD until release.
        add(1'b1, 1'b1, 1'b1, 16'h0200, 16'h0200, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0200, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0200, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0200, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0201, 1'b0, 1'b0, 1'b1);
        // Branch to the current pc still redirects and flushes.
        add(1'b1, 1'b1, 1'b0, 16'h0201, 16'h0201, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0201, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0201, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0202, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].br_valid, vecs[i].jump, vecs[i].stall, vecs[i].target);
            tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_flush,
                     vecs[i].exp_redirect, vecs[i].exp_ready);
        end

        // Wrap FFFF -> 0000 after a branch to FFFF.
        drive(1'b1, 1'b1, 1'b0, 16'hFFFF);
        tick();
        chk_outs("wrap.br", 16'hFFFF, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        tick();
        chk_outs("wrap.run", 16'hFFFF, 1'b0, 1'b0, 1'b1);
        tick();
        chk_outs("wrap.zero", 16'h0000, 1'b0, 1'b0, 1'b1);

        // Reset mid-FLUSH acts immediately and the next edge is normal RUN.
        drive(1'b1, 1'b1, 1'b0, 16'h0400);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk_outs("rstfl.pre", 16'h0400, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk_outs("rstfl.async", 16'h0010, 1'b0, 1'b0, 1'b1);
        #1;
        reset = 1'b0;
        tick();
        chk_outs("rstfl.run", 16'h0011, 1'b0, 1'b0, 1'b1);

        // Reset mid-HOLD abandons the hold.
        drive(1'b0, 1'b0, 1'b1, 16'h0000);
        tick();
        chk_outs("rsthd.pre", 16'h0011, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk_outs("rsthd.async", 16'h0010, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        #1;
        reset = 1'b0;
        tick();
        chk_outs("rsthd.run", 16'h0011, 1'b0, 1'b0, 1'b1);

`ifdef BRANCH_STATS_EN
        // Counts restart from a reset; branches presented during FLUSH do not count.
        reset = 1'b1;
        #1;
        chk("stats.rst_taken", bus.taken_cnt, 16'h0000);
        chk("stats.rst_nt",    bus.nottaken_cnt, 16'h0000);
        #1;
        reset = 1'b0;
        exp_taken = 0;
        exp_nt    = 0;
        for (int i = 0; i < 5; i++) begin
            if ((i % 2) == 0) begin
                drive(1'b1, 1'b1, 1'b0, 16'(16'h0600 + i));
                tick();
                exp_taken++;
                drive(1'b1, 1'b1, 1'b0, 16'h0900);
                tick();
                tick();
                drive(1'b0, 1'b0, 1'b0, 16'h0000);
            end else begin
                drive(1'b1, 1'b0, 1'b0, 16'h0700);
                tick();
                exp_nt++;
                drive(1'b0, 1'b0, 1'b0, 16'h0000);
            end
        end
        tick();
        chk("stats.taken",    bus.taken_cnt,    16'(exp_taken));
        chk("stats.nottaken", bus.nottaken_cnt, 16'(exp_nt));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
